posit_round_sched: RTL
======================

# posit_round_sched

Round-robin scheduler that shares one 32-bit posit rounding datapath among NUM_REQ producer units (adder, multiplier, divider, converter). Each producer offers a 64-bit unrounded word over valid/ready; the block grants one per cycle, rounds it in a registered two-stage pipeline and returns the 32-bit result tagged with the producer index. It sits between the posit arithmetic units and the register-file writeback.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ID_W, $clog2(NUM_REQ): width of the result tag
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scheduler enable; low stops new grants and drains the pipeline
- req_valid  in  NUM_REQ  per-requester offer
- req_data  in  NUM_REQ*64  per-requester unrounded word; slice i is bits [64*i+63 : 64*i]
- req_ready  out  NUM_REQ  one-hot-or-zero grant
- out_valid  out  1  rounded result available
- out_ready  in  1  consumer accepts result
- out_data  out  32  rounded posit
- out_id  out  ID_W  index of the requester that produced out_data
- idle  out  1  high when disabled and pipeline empty

## Operation
- Rounding rule: word W[63:0]; result = W[63:32] + W[31], 32-bit modulo add (0xFFFFFFFF with W[31]=1 gives 0x00000000). W[30:0] ignored.
- Pipeline: S1 register (64-bit word + id), S2 register (32-bit result + id). Rounding adder sits between S1 and S2.
- S2 advances when S2 empty or out_ready. S1 advances when S1 empty or S1 moves into S2. A grant is issued only when S1 can accept.
- Arbitration: round-robin over req_valid, search starts at (last_granted+1) mod NUM_REQ; pointer updates only on an accepted transfer. After reset, requester 0 has highest priority.
- req_ready[i] is combinational from req_valid, pointer, state, en and pipeline space (including out_ready). At most one bit high; a bit is never high without its req_valid.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: no grants, idle=1. en=1 -> RUN.
  - RUN: grants permitted while en=1. en=0 with pipeline non-empty -> DRAIN; en=0 with pipeline empty -> IDLE.
  - DRAIN: no grants; in-flight results still delivered. en=1 -> RUN; pipeline empty -> IDLE.
- Grants are gated by en in the same cycle: en=0 forces req_ready=0 immediately, even in RUN.
- out_data/out_id hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: req_ready=0, out_valid=0, out_data=0, out_id=0, idle=1, state IDLE, pointer at requester 0, S1/S2 empty.
- First grant is possible in the cycle after en rises (IDLE -> RUN takes one edge).
- Latency: transfer accepted at edge k; out_valid=1 after edge k+1 (2 cycles); out_valid=1 and out_ready=1 at edge k+2 completes delivery.
- Throughput: one result per cycle with out_ready held high.
- Backpressure: out_ready=0 fills S2 then S1; req_ready=0 thereafter. Nothing is dropped or duplicated.
- rst_n low mid-operation: all in-flight words discarded, outputs return to reset values asynchronously.

## Structure
- Package posit_round_pkg: WORD_W=32, UNR_W=64, state enum sched_state_t {IDLE, RUN, DRAIN}.
- Sub-module posit_rr_arbiter: parameterised NUM_REQ round-robin arbiter (req, grant-enable, accept strobe in; one-hot grant out; owns pointer).
- Rounding adder and pipeline registers are inline in posit_round_sched.

## Test plan
- Single request: en=1, requester 2 offers 0x40000000_80000000 -> accepted, two cycles later out_data=0x40000001, out_id=2.
- Guard clear and wrap: 0x12345678_7FFFFFFF -> 0x12345678; 0xFFFFFFFF_80000000 -> 0x00000000.
- Fairness: all four requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,1,... and out_id follows that order one per cycle.
- Backpressure: out_ready=0 for 5 cycles with all valid -> exactly 2 words in flight, req_ready=0 after the second accept. On release, results emerge in order with no loss.
- Drain: en drops with 2 words in flight -> req_ready=0 that cycle, 2 results delivered, idle=1 one cycle after the pipeline empties.
- Reset mid-flight: rst_n low while S1/S2 full -> out_valid=0, idle=1 immediately. After release and en=1, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/posit_round_pkg.sv
// Shared widths, scheduler state encoding and the posit rounding helper.
package posit_round_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned UNR_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Round to nearest on the guard bit; the carry out of bit 31 is dropped.
    function automatic logic [WORD_W-1:0] round_word(input logic [UNR_W-1:0] w);
        return w[UNR_W-1:WORD_W] + {{(WORD_W-1){1'b0}}, w[WORD_W-1]};
    endfunction

endpackage

// File: rtl/posit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority rotates past the last accepted requester.
module posit_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               grant_en_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand_idx;
    int unsigned      cand;
    logic             found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand     = (32'(ptr_q) + off) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = grant_en_i;
                grant_idx_o       = cand_idx;
            end
        end
    end

    // Pointer holds the last granted index; resetting to the top gives requester 0 priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (accept_i) begin
            ptr_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/posit_round_sched.sv
// Shares one registered posit rounding datapath among NUM_REQ producers, round-robin.
module posit_round_sched
    import posit_round_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*UNR_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        out_data,
    output logic [ID_W-1:0]          out_id,
    output logic                     idle
);

    sched_state_t state_q, state_d;

    logic              s1_valid_q;
    logic [UNR_W-1:0]  s1_word_q;
    logic [ID_W-1:0]   s1_id_q;
    logic              s2_valid_q;
    logic [WORD_W-1:0] s2_data_q;
    logic [ID_W-1:0]   s2_id_q;

    logic               s2_adv;
    logic               s1_free;
    logic               pipe_empty;
    logic               grant_en;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [UNR_W-1:0]   grant_word;

    assign s2_adv     = !s2_valid_q || out_ready;
    assign s1_free    = !s1_valid_q || s2_adv;
    assign pipe_empty = !s1_valid_q && !s2_valid_q;
    // en gates grants combinationally so a falling en blocks the same cycle.
    assign grant_en   = (state_q == RUN) && en && s1_free;
    assign accept     = |(req_valid & grant);
    assign grant_word = req_data[32'(grant_idx) * UNR_W +: UNR_W];

    posit_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arbiter (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req_valid),
        .grant_en_i  (grant_en),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) state_d = pipe_empty ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (pipe_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            if (s1_free) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_word_q <= grant_word;
                    s1_id_q   <= grant_idx;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= round_word(s1_word_q);
                    s2_id_q   <= s1_id_q;
                end
            end
        end
    end

    assign req_ready = grant;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_id    = s2_id_q;
    assign idle      = (state_q == IDLE);

endmodule
